// File: rtl/game_screen_controller.sv
// Game phase sequencer for the hole-in-the-wall display: lives, score, wall launch
// pulses, and a frame-aligned pixel mux over the title/gameplay/game-over streams.
module game_screen_controller #(
  parameter int START_LIVES       = 3,
  parameter int WALL_PAUSE_FRAMES = 60,
  parameter int GAMEOVER_FRAMES   = 300,
  parameter int SCORE_WIDTH       = 8
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   new_frame_in,
  input  logic                   start_btn_in,
  input  logic                   wall_passed_in,
  input  logic                   wall_hit_in,
  input  logic [23:0]            title_pixel_in,
  input  logic [23:0]            game_pixel_in,
  input  logic [23:0]            game_over_pixel_in,
  output logic [23:0]            pixel_out,
  output logic [1:0]             state_out,
  output logic [2:0]             lives_out,
  output logic [SCORE_WIDTH-1:0] score_out,
  output logic                   wall_start_out
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_PLAYING   = 2'd1;
  localparam logic [1:0] S_PAUSE     = 2'd2;
  localparam logic [1:0] S_GAME_OVER = 2'd3;

  localparam int MAX_FRAMES = (WALL_PAUSE_FRAMES > GAMEOVER_FRAMES) ?
                              WALL_PAUSE_FRAMES : GAMEOVER_FRAMES;
  localparam int CNT_W = $clog2(MAX_FRAMES + 1);
  localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'(WALL_PAUSE_FRAMES - 1);
  localparam logic [CNT_W-1:0] OVER_LAST  = CNT_W'(GAMEOVER_FRAMES - 1);

  logic [1:0]             state_q, state_d;
  logic [1:0]             display_sel_q, display_sel_d;
  logic [2:0]             lives_q, lives_d;
  logic [SCORE_WIDTH-1:0] score_q, score_d;
  logic [CNT_W-1:0]       frame_cnt_q, frame_cnt_d;
  logic                   wall_start_q, wall_start_d;
  logic [23:0]            pixel_q, pixel_d;
  logic                   start_prev_q;
  logic                   start_edge;

  assign start_edge = start_btn_in & ~start_prev_q;

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    lives_d      = lives_q;
    score_d      = score_q;
    frame_cnt_d  = frame_cnt_q;
    wall_start_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d      = S_PLAYING;
          lives_d      = 3'(START_LIVES);
          score_d      = '0;
          frame_cnt_d  = '0;
          wall_start_d = 1'b1;
        end
      end
      S_PLAYING: begin
        // A simultaneous hit and pass counts as a hit only.
        if (wall_hit_in) begin
          lives_d     = lives_q - 3'd1;
          state_d     = (lives_q == 3'd1) ? S_GAME_OVER : S_PAUSE;
          frame_cnt_d = '0;
        end else if (wall_passed_in) begin
          if (score_q != '1) score_d = score_q + SCORE_WIDTH'(1);
          state_d     = S_PAUSE;
          frame_cnt_d = '0;
        end
      end
      S_PAUSE: begin
        if (new_frame_in) begin
          if (frame_cnt_q == PAUSE_LAST) begin
            state_d      = S_PLAYING;
            frame_cnt_d  = '0;
            wall_start_d = 1'b1;
          end else begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        if (new_frame_in) begin
          if (frame_cnt_q == OVER_LAST) begin
            state_d     = S_IDLE;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
          end
        end
      end
    endcase
  end

  // Screen choice only moves at frame boundaries so a frame never mixes screens.
  always_comb begin
    display_sel_d = new_frame_in ? state_q : display_sel_q;
    case (display_sel_q)
      S_IDLE:      pixel_d = title_pixel_in;
      S_GAME_OVER: pixel_d = game_over_pixel_in;
      default:     pixel_d = game_pixel_in;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= S_IDLE;
      display_sel_q <= S_IDLE;
      lives_q       <= '0;
      score_q       <= '0;
      frame_cnt_q   <= '0;
      wall_start_q  <= 1'b0;
      pixel_q       <= '0;
      start_prev_q  <= 1'b1;  // a button held through reset must not start a game
    end else begin
      state_q       <= state_d;
      display_sel_q <= display_sel_d;
      lives_q       <= lives_d;
      score_q       <= score_d;
      frame_cnt_q   <= frame_cnt_d;
      wall_start_q  <= wall_start_d;
      pixel_q       <= pixel_d;
      start_prev_q  <= start_btn_in;
    end
  end

  assign pixel_out      = pixel_q;
  assign state_out      = state_q;
  assign lives_out      = lives_q;
  assign score_out      = score_q;
  assign wall_start_out = wall_start_q;

endmodule

// File: tb/tb_game_screen_controller.sv
// Directed bench for game_screen_controller: start edge, pause/game-over timing,
// lives/score bookkeeping, frame-aligned pixel mux and mid-pause reset.
module tb_game_screen_controller;

  localparam int SW = 2;
  localparam logic [23:0] TITLE = 24'h0000FF;
  localparam logic [23:0] GAME  = 24'h00FF00;
  localparam logic [23:0] OVER  = 24'h800000;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          new_frame_in = 1'b0;
  logic          start_btn_in = 1'b1;
  logic          wall_passed_in = 1'b0;
  logic          wall_hit_in = 1'b0;
  logic [23:0]   title_pixel_in = TITLE;
  logic [23:0]   game_pixel_in = GAME;
  logic [23:0]   game_over_pixel_in = OVER;
  logic [23:0]   pixel_out;
  logic [1:0]    state_out;
  logic [2:0]    lives_out;
  logic [SW-1:0] score_out;
  logic          wall_start_out;

  int checks = 0;
  int errors = 0;
  int wall_seen;

  game_screen_controller #(
    .START_LIVES(3), .WALL_PAUSE_FRAMES(60), .GAMEOVER_FRAMES(300), .SCORE_WIDTH(SW)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .new_frame_in(new_frame_in),
    .start_btn_in(start_btn_in), .wall_passed_in(wall_passed_in),
    .wall_hit_in(wall_hit_in), .title_pixel_in(title_pixel_in),
    .game_pixel_in(game_pixel_in), .game_over_pixel_in(game_over_pixel_in),
    .pixel_out(pixel_out), .state_out(state_out), .lives_out(lives_out),
    .score_out(score_out), .wall_start_out(wall_start_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; outputs are sampled 1 time unit after it.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      new_frame_in = 1'b1; tick();
      new_frame_in = 1'b0; tick();
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"}, 32'(state_out), 32'd0);
    check({tag, "_lives"}, 32'(lives_out), 32'd0);
    check({tag, "_score"}, 32'(score_out), 32'd0);
    check({tag, "_wall"},  32'(wall_start_out), 32'd0);
    check({tag, "_pixel"}, 32'(pixel_out), 32'h0);
  endtask

  // Run the remaining pause after a fresh entry into PAUSE, ending in PLAYING.
  task automatic finish_pause(input string tag);
    frames(59);
    check({tag, "_still_pause"}, 32'(state_out), 32'd2);
    check({tag, "_no_wall"}, 32'(wall_start_out), 32'd0);
    new_frame_in = 1'b1; tick();
    new_frame_in = 1'b0;
    check({tag, "_resume"}, 32'(state_out), 32'd1);
    check({tag, "_wall_hi"}, 32'(wall_start_out), 32'd1);
    tick();
    check({tag, "_wall_lo"}, 32'(wall_start_out), 32'd0);
  endtask

  initial begin
    // Reset with the button held, then keep holding: no game may start.
    tick(2);
    check_reset("rst");
    rst_in = 1'b0;
    wall_seen = 0;
    repeat (10) begin
      tick();
      if (wall_start_out || state_out != 2'd0) wall_seen++;
    end
    check("held_btn_no_start", 32'(wall_seen), 32'd0);
    check("idle_title_pixel", 32'(pixel_out), 32'(TITLE));

    // Release and re-press.
    start_btn_in = 1'b0; tick();
    start_btn_in = 1'b1; tick();
    check("start_state", 32'(state_out), 32'd1);
    check("start_lives", 32'(lives_out), 32'd3);
    check("start_score", 32'(score_out), 32'd0);
    check("start_wall_hi", 32'(wall_start_out), 32'd1);
    tick();
    check("start_wall_lo", 32'(wall_start_out), 32'd0);

    // Pass a wall; inputs during PAUSE are ignored.
    wall_passed_in = 1'b1; tick(); wall_passed_in = 1'b0;
    check("pass_score", 32'(score_out), 32'd1);
    check("pass_state", 32'(state_out), 32'd2);
    check("midframe_pixel_title", 32'(pixel_out), 32'(TITLE));
    wall_hit_in = 1'b1; tick(); wall_hit_in = 1'b0;
    check("pause_hit_ignored", 32'(lives_out), 32'd3);
    finish_pause("p1");
    check("game_pixel", 32'(pixel_out), 32'(GAME));

    // Hit and pass together: the hit wins.
    wall_hit_in = 1'b1; wall_passed_in = 1'b1; tick();
    wall_hit_in = 1'b0; wall_passed_in = 1'b0;
    check("both_lives", 32'(lives_out), 32'd2);
    check("both_score", 32'(score_out), 32'd1);
    check("both_state", 32'(state_out), 32'd2);
    finish_pause("p2");

    wall_hit_in = 1'b1; tick(); wall_hit_in = 1'b0;
    check("hit2_lives", 32'(lives_out), 32'd1);
    check("hit2_state", 32'(state_out), 32'd2);
    finish_pause("p3");

    // Last life, mid-frame: screen changes only after the next frame boundary.
    wall_hit_in = 1'b1; tick(); wall_hit_in = 1'b0;
    check("hit3_lives", 32'(lives_out), 32'd0);
    check("hit3_state", 32'(state_out), 32'd3);
    tick(3);
    check("go_pixel_hold", 32'(pixel_out), 32'(GAME));
    new_frame_in = 1'b1; tick(); new_frame_in = 1'b0;
    check("go_pixel_at_frame", 32'(pixel_out), 32'(GAME));
    tick();
    check("go_pixel_after", 32'(pixel_out), 32'(OVER));
    frames(298);
    check("go_still", 32'(state_out), 32'd3);
    start_btn_in = 1'b0; tick(); start_btn_in = 1'b1; tick();
    check("go_start_ignored", 32'(state_out), 32'd3);
    new_frame_in = 1'b1; tick(); new_frame_in = 1'b0;
    check("go_to_idle", 32'(state_out), 32'd0);
    check("go_score_held", 32'(score_out), 32'd1);
    check("go_lives_held", 32'(lives_out), 32'd0);
    tick();
    check("idle_pixel_old_screen", 32'(pixel_out), 32'(OVER));
    frames(1);
    check("idle_pixel_title", 32'(pixel_out), 32'(TITLE));

    // New game, four passes: score saturates at 3.
    start_btn_in = 1'b0; tick(); start_btn_in = 1'b1; tick();
    check("g2_state", 32'(state_out), 32'd1);
    check("g2_score", 32'(score_out), 32'd0);
    check("g2_lives", 32'(lives_out), 32'd3);
    for (int i = 0; i < 3; i++) begin
      wall_passed_in = 1'b1; tick(); wall_passed_in = 1'b0;
      check("sat_score", 32'(score_out), 32'(i + 1));
      finish_pause("sat");
    end
    wall_passed_in = 1'b1; tick(); wall_passed_in = 1'b0;
    check("sat_score_max", 32'(score_out), 32'd3);
    check("sat_state", 32'(state_out), 32'd2);

    // Reset mid-pause, with the button still held.
    frames(5);
    rst_in = 1'b1; tick();
    check_reset("midrst");
    rst_in = 1'b0; tick(2);
    check("post_rst_held_btn", 32'(state_out), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
